// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic adder sequencer: FSM states, LFSR geometry
// and the default reload seeds of the three stream generators.
package stoch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LFSR_W = 8;

  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS  = 8'hB8;
  localparam logic [LFSR_W-1:0] SEL_THRESH = 8'd127;

  localparam logic [LFSR_W-1:0] DEF_SEED_A = 8'h5A;
  localparam logic [LFSR_W-1:0] DEF_SEED_B = 8'hC3;
  localparam logic [LFSR_W-1:0] DEF_SEED_S = 8'h1F;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/stoch_sng.sv
// Stochastic number generator: 8-bit Fibonacci LFSR with seed reload and a
// less-or-equal comparator against a threshold.
module stoch_sng
  import stoch_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEF_SEED_A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [LFSR_W-1:0] thresh_i,
  output logic              bit_o
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = (lfsr_q <= thresh_i);

endmodule

// File: rtl/stochastic_add_sequencer.sv
// Sequencer for a mux-based stochastic adder: generates A, B and select streams
// for BIT_LENGTH cycles and counts the ones returned on y_bit.
module stochastic_add_sequencer
  import stoch_pkg::*;
#(
  parameter int          BIT_LENGTH = 128,
  parameter logic [7:0]  SEED_A     = DEF_SEED_A,
  parameter logic [7:0]  SEED_B     = DEF_SEED_B,
  parameter logic [7:0]  SEED_S     = DEF_SEED_S
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [7:0]                    a_val,
  input  logic [7:0]                    b_val,
  output logic                          a_bit,
  output logic                          b_bit,
  output logic                          sel_bit,
  input  logic                          y_bit,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(BIT_LENGTH):0]   result
);

  localparam int IDX_W = $clog2(BIT_LENGTH);
  localparam int CNT_W = IDX_W + 1;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] ones_q;
  logic [CNT_W-1:0] ones_d;
  logic [CNT_W-1:0] result_q;
  logic [7:0]       a_lat_q;
  logic [7:0]       b_lat_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             run;
  logic             last;
  logic [2:0]       cmp;
  logic [7:0]       thresh [3];

  assign load   = (state_q == ST_IDLE) && start;
  assign run    = (state_q == ST_RUN);
  assign last   = run && (idx_q == IDX_W'(BIT_LENGTH - 1));
  assign ones_d = ones_q + CNT_W'(y_bit);

  assign thresh[0] = a_lat_q;
  assign thresh[1] = b_lat_q;
  assign thresh[2] = SEL_THRESH;

  for (genvar gi = 0; gi < 3; gi++) begin : g_sng
    localparam logic [7:0] SEED = (gi == 0) ? SEED_A : ((gi == 1) ? SEED_B : SEED_S);
    stoch_sng #(
      .SEED(SEED)
    ) u_sng (
      .clk      (clk),
      .rst      (rst),
      .load_i   (load),
      .en_i     (run),
      .thresh_i (thresh[gi]),
      .bit_o    (cmp[gi])
    );
  end

  // Stream bits come only from registered LFSR/latch state, gated by RUN.
  assign a_bit   = run & cmp[0];
  assign b_bit   = run & cmp[1];
  assign sel_bit = run & cmp[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      ones_q   <= '0;
      result_q <= '0;
      a_lat_q  <= '0;
      b_lat_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_lat_q  <= a_val;
            b_lat_q  <= b_val;
            idx_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          ones_q <= ones_d;
          idx_q  <= idx_q + 1'b1;
          if (last) begin
            result_q <= ones_d;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_stochastic_add_sequencer.sv
// Scoreboard bench for stochastic_add_sequencer: a mux adder closes the loop and
// an independent LFSR model predicts streams and results.
module tb_stochastic_add_sequencer;

  localparam int BL = 128;
  localparam int RW = $clog2(BL) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    a_val = 8'd0;
  logic [7:0]    b_val = 8'd0;
  logic          a_bit, b_bit, sel_bit, y_bit, busy, done;
  logic [RW-1:0] result;

  // Stochastic adder: y = sel ? b : a
  assign y_bit = sel_bit ? b_bit : a_bit;

  always #5 clk = ~clk;

  stochastic_add_sequencer #(
    .BIT_LENGTH(BL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_val   (a_val),
    .b_val   (b_val),
    .a_bit   (a_bit),
    .b_bit   (b_bit),
    .sel_bit (sel_bit),
    .y_bit   (y_bit),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  typedef struct {
    logic [7:0]    a;
    logic [7:0]    b;
    int            res;
    logic [BL-1:0] sa;
    logic [BL-1:0] sb;
    logic [BL-1:0] ss;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [7:0] step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [7:0] la = 8'h5A;
    logic [7:0] lb = 8'hC3;
    logic [7:0] ls = 8'h1F;
    e.a = a;
    e.b = b;
    e.res = 0;
    for (int i = 0; i < BL; i++) begin
      e.sa[i] = (la <= a);
      e.sb[i] = (lb <= b);
      e.ss[i] = (ls <= 8'd127);
      if (e.ss[i] ? e.sb[i] : e.sa[i]) e.res++;
      la = step(la);
      lb = step(lb);
      ls = step(ls);
    end
    return e;
  endfunction

  // Monitor: captures RUN streams, checks each DONE against the scoreboard.
  int            neg_cnt = 0;
  int            start_neg = 0;
  int            done_seen = 0;
  int            res_bad = 0;
  int            idx;
  bit            in_run = 1'b0;
  bit            prev_done = 1'b0;
  logic [RW-1:0] held;
  logic [BL-1:0] oa, ob, os;
  exp_t          e_mon;

  always @(negedge clk) begin
    neg_cnt++;
    if (prev_done) begin
      check("done_pulse", done, 0);
      check("busy_idle", busy, 0);
      check("res_hold", result, held);
      check("bits_idle", {a_bit, b_bit, sel_bit}, 0);
    end
    prev_done = 1'b0;
    if (rst) begin
      in_run = 1'b0;
    end else if (busy && !done) begin
      if (!in_run) begin
        in_run = 1'b1;
        start_neg = neg_cnt;
        oa = '0;
        ob = '0;
        os = '0;
        res_bad = 0;
      end
      idx = neg_cnt - start_neg;
      if (idx < BL) begin
        oa[idx] = a_bit;
        ob[idx] = b_bit;
        os[idx] = sel_bit;
      end
      if (result != 0) res_bad++;
    end else if (done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e_mon = sb_q.pop_front();
        check("latency", in_run ? (neg_cnt - start_neg) : 0, BL);
        check("result", result, e_mon.res);
        check("a_stream", oa, e_mon.sa);
        check("b_stream", ob, e_mon.sb);
        check("sel_stream", os, e_mon.ss);
        check("res_zero_in_run", res_bad, 0);
        check("busy_in_done", busy, 1);
        if (e_mon.a == 8'hFF) check("a_all_ones", oa, {BL{1'b1}});
        if (e_mon.a == 8'h00) check("a_all_zero", oa, 0);
        $display("[TB] run a=%0d b=%0d result=%0d expected=%0d", e_mon.a, e_mon.b, result, e_mon.res);
      end
      in_run = 1'b0;
      prev_done = 1'b1;
      held = result;
    end else begin
      in_run = 1'b0;
    end
  end

  int want = 0;

  task automatic wait_done();
    want++;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (done_seen >= want) break;
    end
    if (done_seen < want) begin
      check("done_timeout", done_seen, want);
      want = done_seen;
    end
  endtask

  task automatic start_run(input logic [7:0] a, input logic [7:0] b, input bit push);
    @(negedge clk);
    a_val = a;
    b_val = b;
    start = 1'b1;
    if (push) sb_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] b);
    start_run(a, b, 1'b1);
    wait_done();
  endtask

  logic [RW-1:0] r1;
  logic [BL-1:0] s1a, s1b, s1s;
  int            d0;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_bits", {a_bit, b_bit, sel_bit}, 0);
    #1 rst = 1'b0;

    run_one(8'd0, 8'd0);
    run_one(8'd255, 8'd255);
    run_one(8'd0, 8'd255);

    run_one(8'd128, 8'd64);
    r1 = result;
    s1a = oa;
    s1b = ob;
    s1s = os;
    run_one(8'd128, 8'd64);
    check("repeat_result", result, r1);
    check("repeat_a", oa, s1a);
    check("repeat_b", ob, s1b);
    check("repeat_sel", os, s1s);

    for (int k = 0; k < 2; k++) begin
      run_one(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Abort mid-RUN with an asynchronous reset at RUN cycle 50.
    start_run(8'd100, 8'd200, 1'b0);
    repeat (49) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_bits", {a_bit, b_bit, sel_bit}, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    d0 = done_seen;
    repeat (200) @(negedge clk);
    #1;
    check("no_done_after_abort", done_seen, d0);
    check("abort_result_idle", result, 0);
    run_one(8'd100, 8'd200);

    // Start held high: one run, then a restart only from the IDLE cycle after DONE.
    @(negedge clk);
    a_val = 8'd77;
    b_val = 8'd190;
    start = 1'b1;
    sb_q.push_back(model(8'd77, 8'd190));
    sb_q.push_back(model(8'd77, 8'd190));
    wait_done();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("restart_from_idle", busy, 1);
    start = 1'b0;
    wait_done();

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
